// File: rtl/runner_pkg.sv
// Shared types and helpers for the motion/gesture filter.
package runner_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMING   = 2'd1,
        ACTIVE   = 2'd2,
        COOLDOWN = 2'd3
    } chan_state_t;

    localparam int JUMP_CH = 0;
    localparam int DUCK_CH = 1;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/motion_filter_chan.sv
// One gesture channel: debounce/hysteresis/cooldown FSM for sensor mode,
// plus a 2-flop button synchroniser for manual mode, behind one output register.
module motion_filter_chan #(
    parameter int DATA_W   = 16,
    parameter int DEBOUNCE = 4,
    parameter int COOLDOWN = 1000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sample_valid,
    input  logic signed [DATA_W-1:0] sample,
    input  logic signed [DATA_W-1:0] on_th,
    input  logic signed [DATA_W-1:0] off_th,
    input  logic                     btn,
    input  logic                     manual,
    output logic                     level,
    output logic                     pulse
);
    import runner_pkg::*;

    localparam int CNT_W = cnt_width(DEBOUNCE);
    localparam int TMR_W = cnt_width(COOLDOWN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(COOLDOWN);

    chan_state_t state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic sync1_q, sync2_q, manual_q;
    logic level_q, level_d, pulse_q, pulse_d;
    logic signed [DATA_W-1:0] eff_off_s;
    logic at_on_s, below_off_s;

    // Threshold compares; a release level above the trigger level is clamped to it.
    always_comb begin
        eff_off_s   = (off_th < on_th) ? off_th : on_th;
        at_on_s     = (sample >= on_th);
        below_off_s = (sample < eff_off_s);
    end

    // Next-state logic for the gesture FSM, debounce counter and cooldown timer.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        timer_d = timer_q;
        if (manual) begin
            state_d = IDLE;
            count_d = '0;
            timer_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sample_valid && at_on_s) begin
                        if (DEBOUNCE == 1) begin
                            state_d = ACTIVE;
                            count_d = '0;
                        end else begin
                            state_d = ARMING;
                            count_d = CNT_W'(1);
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                ARMING: begin
                    if (sample_valid && at_on_s) begin
                        if (count_q == CNT_LAST) begin
                            state_d = ACTIVE;
                            count_d = '0;
                        end else begin
                            count_d = count_q + CNT_W'(1);
                        end
                    end else if (sample_valid) begin
                        state_d = IDLE;
                        count_d = '0;
                    end else begin
                        state_d = ARMING;
                    end
                end
                ACTIVE: begin
                    if (sample_valid && below_off_s) begin
                        if (COOLDOWN == 0) begin
                            state_d = IDLE;
                        end else begin
                            state_d = runner_pkg::COOLDOWN;
                            timer_d = TMR_LOAD;
                        end
                    end else begin
                        state_d = ACTIVE;
                    end
                end
                runner_pkg::COOLDOWN: begin
                    // Runs on every clock; samples are not consulted here.
                    if (timer_q <= TMR_W'(1)) begin
                        state_d = IDLE;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q - TMR_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                    timer_d = '0;
                end
            endcase
        end
    end

    // Output source select; manual_q suppresses a pulse on the cycle the source changes.
    always_comb begin
        level_d = 1'b0;
        pulse_d = 1'b0;
        if (manual) begin
            level_d = sync2_q;
            pulse_d = sync2_q & ~level_q & manual_q;
        end else begin
            level_d = (state_d == ACTIVE);
            pulse_d = (state_d == ACTIVE) && (state_q != ACTIVE);
        end
    end

    // State, counters, synchroniser and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            timer_q  <= '0;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            manual_q <= 1'b0;
            level_q  <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            timer_q  <= timer_d;
            sync1_q  <= btn;
            sync2_q  <= sync1_q;
            manual_q <= manual;
            level_q  <= level_d;
            pulse_q  <= pulse_d;
        end
    end

    assign level = level_q;
    assign pulse = pulse_q;

endmodule

// File: rtl/motion_filter.sv
// Gesture filter top: one independent motion_filter_chan per channel.
module motion_filter #(
    parameter int CHANNELS = 2,
    parameter int DATA_W   = 16,
    parameter int DEBOUNCE = 4,
    parameter int COOLDOWN = 1000
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               sample_valid,
    input  logic [CHANNELS-1:0][DATA_W-1:0]    sample,
    input  logic [CHANNELS-1:0][DATA_W-1:0]    on_th,
    input  logic [CHANNELS-1:0][DATA_W-1:0]    off_th,
    input  logic [CHANNELS-1:0]                btn,
    input  logic                               manual,
    output logic [CHANNELS-1:0]                level,
    output logic [CHANNELS-1:0]                pulse
);

    // Each lane is reinterpreted as signed at the channel port.
    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
        motion_filter_chan #(
            .DATA_W  (DATA_W),
            .DEBOUNCE(DEBOUNCE),
            .COOLDOWN(COOLDOWN)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .sample_valid(sample_valid),
            .sample      (sample[ch]),
            .on_th       (on_th[ch]),
            .off_th      (off_th[ch]),
            .btn         (btn[ch]),
            .manual      (manual),
            .level       (level[ch]),
            .pulse       (pulse[ch])
        );
    end

endmodule

// File: tb/tb_motion_filter.sv
// Directed bench for motion_filter with default parameters.
module tb_motion_filter;
    import runner_pkg::*;

    localparam int CH = 2;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst;
    logic sample_valid;
    logic [CH-1:0][DW-1:0] sample, on_th, off_th;
    logic [CH-1:0] btn, level, pulse;
    logic manual;

    int cmp_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    motion_filter #(.CHANNELS(CH), .DATA_W(DW), .DEBOUNCE(4), .COOLDOWN(1000)) dut (
        .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample(sample),
        .on_th(on_th), .off_th(off_th), .btn(btn), .manual(manual),
        .level(level), .pulse(pulse)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic chk(input string tag, input logic [1:0] exp_lv, input logic [1:0] exp_pu);
        cmp_cnt++;
        assert (level === exp_lv && pulse === exp_pu) else begin
            err_cnt++;
            $error("FAIL %s: level=%b pulse=%b expected level=%b pulse=%b", tag, level, pulse, exp_lv, exp_pu);
        end
    endtask

    task automatic vs(input logic [DW-1:0] s0, input logic [DW-1:0] s1);
        sample[JUMP_CH] = s0;
        sample[DUCK_CH] = s1;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        sample_valid = 1'b0;
        sample = '0;
        on_th[0] = 16'sd100;  on_th[1] = 16'sd100;
        off_th[0] = 16'sd50;  off_th[1] = 16'sd50;
        btn = 2'b00;
        manual = 1'b0;

        idle(2);
        chk("reset", 2'b00, 2'b00);
        rst = 1'b0;
        tick();
        chk("post_reset", 2'b00, 2'b00);

        // Debounce with an interrupted run and idle (invalid) cycles in between
        vs(16'sd120, 16'sd0);
        chk("arm1", 2'b00, 2'b00);
        vs(16'sd120, 16'sd0);
        idle(2);
        chk("invalid_hold", 2'b00, 2'b00);
        vs(16'sd120, 16'sd0);
        vs(16'sd90, 16'sd0);
        chk("drop_90", 2'b00, 2'b00);
        vs(16'sd120, 16'sd0);
        vs(16'sd120, 16'sd0);
        vs(16'sd120, 16'sd0);
        chk("rearm_3", 2'b00, 2'b00);
        vs(16'sd120, 16'sd0);
        chk("trig", 2'b01, 2'b01);
        tick();
        chk("pulse_1cyc", 2'b01, 2'b00);

        // Hysteresis, release and cooldown lockout
        vs(16'sd60, 16'sd0);
        chk("hyst_60", 2'b01, 2'b00);
        vs(16'sd40, 16'sd0);
        chk("release_40", 2'b00, 2'b00);
        repeat (4) vs(16'sd120, 16'sd0);
        chk("cool_ignored", 2'b00, 2'b00);
        idle(995);
        vs(16'sd120, 16'sd0);
        chk("cool_last_edge", 2'b00, 2'b00);
        repeat (3) vs(16'sd120, 16'sd0);
        chk("after_cool_3", 2'b00, 2'b00);
        vs(16'sd120, 16'sd0);
        chk("after_cool_trig", 2'b01, 2'b01);

        // Asynchronous reset mid-ACTIVE (ch0) and mid-ARMING (ch1)
        vs(16'sd120, 16'sd120);
        vs(16'sd120, 16'sd120);
        chk("pre_rst", 2'b01, 2'b00);
        #2 rst = 1'b1;
        #1 chk("rst_async", 2'b00, 2'b00);
        #1 rst = 1'b0;
        tick();
        chk("rst_release", 2'b00, 2'b00);
        repeat (3) vs(16'sd120, 16'sd120);
        chk("no_pulse_after_rst", 2'b00, 2'b00);
        vs(16'sd120, 16'sd120);
        chk("both_trig", 2'b11, 2'b11);

        // off_th above on_th clamps release to on_th
        off_th[0] = 16'sd200;
        vs(16'sd150, 16'sd120);
        chk("eff_off_hold", 2'b11, 2'b00);
        vs(16'sd99, 16'sd120);
        chk("eff_off_rel", 2'b10, 2'b00);

        // Signed thresholds on ch1
        rst = 1'b1;
        tick();
        rst = 1'b0;
        off_th[0] = 16'sd50;
        on_th[1] = -16'sd10;
        off_th[1] = -16'sd20;
        repeat (3) vs(16'sd0, 16'sd5);
        chk("signed_arm", 2'b00, 2'b00);
        vs(16'sd0, 16'sd5);
        chk("signed_trig", 2'b10, 2'b10);
        vs(16'sd0, -16'sd15);
        chk("signed_hold", 2'b10, 2'b00);
        vs(16'sd0, -16'sd25);
        chk("signed_rel", 2'b00, 2'b00);
        on_th[1] = 16'sd100;
        off_th[1] = 16'sd50;

        // Button mode: 2-flop sync latency, glitch rejection, FSMs held idle
        manual = 1'b1;
        tick();
        chk("manual_enter", 2'b00, 2'b00);
        btn[1] = 1'b1;
        tick();
        chk("btn_k", 2'b00, 2'b00);
        tick();
        chk("btn_k1", 2'b00, 2'b00);
        tick();
        chk("btn_rise", 2'b10, 2'b10);
        tick();
        chk("btn_pulse_1cyc", 2'b10, 2'b00);
        btn[1] = 1'b0;
        #2 btn[1] = 1'b1;
        tick();
        repeat (4) vs(16'sd120, 16'sd120);
        chk("bounce_hold", 2'b10, 2'b00);
        btn[1] = 1'b0;
        idle(3);
        chk("btn_fall", 2'b00, 2'b00);
        btn[1] = 1'b1;
        idle(2);
        chk("btn_rise2_wait", 2'b00, 2'b00);
        tick();
        chk("btn_rise2", 2'b10, 2'b10);
        tick();
        chk("btn_rise2_1cyc", 2'b10, 2'b00);

        // Back to sensor mode: counters were held clear while manual
        manual = 1'b0;
        tick();
        chk("to_sensor", 2'b00, 2'b00);
        repeat (3) vs(16'sd120, 16'sd120);
        chk("sensor_3", 2'b00, 2'b00);
        vs(16'sd120, 16'sd120);
        chk("sensor_trig", 2'b11, 2'b11);
        btn = 2'b11;
        idle(2);
        chk("sensor_ignores_btn", 2'b11, 2'b00);
        vs(16'sd120, 16'sd40);
        chk("ch1_release", 2'b01, 2'b00);

        // Switch to an already-high button source: no pulse
        manual = 1'b1;
        tick();
        chk("to_manual_nopulse", 2'b11, 2'b00);
        tick();
        chk("to_manual_hold", 2'b11, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
